uart_rdata_sender: RTL and testbench

- Transmit-side partner of the monitor dump logic.
- Accepts a 64-bit dump beat plus a one-cycle start pulse and renders it as ASCII hex text: two 8-digit words, a separator, then an end-of-line.
- Pushes the text one byte at a time into the UART TX write queue.
- Once the queue has drained, returns a one-cycle flushing_wq pulse so the dump sequencer can fetch the next beat.

---
 rtl/uart_mon_pkg.sv | 17 +
 rtl/hex_nibble_ascii.sv | 17 +
 rtl/uart_rdata_sender.sv | 113 +++++++++++
 tb/tb_uart_rdata_sender.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_mon_pkg.sv
// Shared encodings for the UART monitor dump path: sender FSM states and ASCII constants.
package uart_mon_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } snd_state_e;

  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_A  = 8'h41;

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational 4-bit nibble to uppercase ASCII hex digit.
module hex_nibble_ascii
  import uart_mon_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) begin
      ascii_o = ASC_0 + {4'h0, nibble_i};
    end else begin
      ascii_o = ASC_A + {4'h0, nibble_i} - 8'd10;
    end
  end

endmodule

// File: rtl/uart_rdata_sender.sv
// Renders one 64-bit dump beat as an ASCII hex line into the UART TX queue,
// then pulses flushing_wq once the queue has drained.
module uart_rdata_sender
  import uart_mon_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = 8'h20,
  parameter bit         EOL_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdata_snd_start,
  input  logic [63:0] rdata_snd,
  input  logic        snd_abort,
  input  logic        tx_full,
  input  logic        tx_empty,
  output logic [7:0]  tx_wdata,
  output logic        tx_we,
  output logic        flushing_wq,
  output logic        snd_busy
);

  localparam logic [4:0] LastIdx = EOL_CRLF ? 5'd18 : 5'd17;

  snd_state_e  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [63:0] hold_q, hold_d;

  logic [4:0]  idx_m1;
  logic [3:0]  nib_pos;
  logic [63:0] hold_shifted;
  logic [7:0]  hex_char;
  logic [7:0]  cur_byte;

  // Index 8 is the separator, so digits after it sit one position lower.
  assign idx_m1       = idx_q - 5'd1;
  assign nib_pos      = (idx_q < 5'd8) ? idx_q[3:0] : idx_m1[3:0];
  assign hold_shifted = hold_q << {nib_pos, 2'b00};

  hex_nibble_ascii u_hex (
    .nibble_i (hold_shifted[63:60]),
    .ascii_o  (hex_char)
  );

  always_comb begin
    if (idx_q == 5'd8) begin
      cur_byte = SEP_CHAR;
    end else if (idx_q <= 5'd16) begin
      cur_byte = hex_char;
    end else if (idx_q == 5'd17 && EOL_CRLF) begin
      cur_byte = ASC_CR;
    end else begin
      cur_byte = ASC_LF;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    tx_we       = 1'b0;
    tx_wdata    = 8'h00;
    flushing_wq = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rdata_snd_start && !snd_abort) begin
          hold_d  = rdata_snd;
          idx_d   = 5'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (snd_abort) begin
          state_d = S_IDLE;
        end else if (!tx_full) begin
          tx_we    = 1'b1;
          tx_wdata = cur_byte;
          if (idx_q == LastIdx) begin
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      S_DRAIN: begin
        if (snd_abort) begin
          state_d = S_IDLE;
        end else if (tx_empty) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        flushing_wq = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign snd_busy = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 5'd0;
      hold_q  <= 64'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_uart_rdata_sender.sv
// Directed and randomized line checks for uart_rdata_sender (CRLF and LF-only builds).
module tb_uart_rdata_sender;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdata_snd_start;
  logic [63:0] rdata_snd;
  logic        snd_abort;
  logic        tx_full;
  logic        tx_empty;

  logic [7:0]  wd1, wd0;
  logic        we1, we0, fl1, fl0, bz1, bz0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rdata_sender #(.SEP_CHAR(8'h20), .EOL_CRLF(1'b1)) u_dut_crlf (
    .clk             (clk),
    .rst             (rst),
    .rdata_snd_start (rdata_snd_start),
    .rdata_snd       (rdata_snd),
    .snd_abort       (snd_abort),
    .tx_full         (tx_full),
    .tx_empty        (tx_empty),
    .tx_wdata        (wd1),
    .tx_we           (we1),
    .flushing_wq     (fl1),
    .snd_busy        (bz1)
  );

  uart_rdata_sender #(.SEP_CHAR(8'h20), .EOL_CRLF(1'b0)) u_dut_lf (
    .clk             (clk),
    .rst             (rst),
    .rdata_snd_start (rdata_snd_start),
    .rdata_snd       (rdata_snd),
    .snd_abort       (snd_abort),
    .tx_full         (tx_full),
    .tx_empty        (tx_empty),
    .tx_wdata        (wd0),
    .tx_we           (we0),
    .flushing_wq     (fl0),
    .snd_busy        (bz0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hex_of(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
  endfunction

  // Reference line: 8 upper digits, space, 8 lower digits, optional CR, LF.
  task automatic build_line(input logic [63:0] d, input bit crlf, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(hex_of(d[63-4*i -: 4]));
    q.push_back(8'h20);
    for (int i = 0; i < 8; i++) q.push_back(hex_of(d[31-4*i -: 4]));
    if (crlf) q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  task automatic settle();
    rdata_snd_start = 1'b0;
    snd_abort       = 1'b0;
    tx_full         = 1'b0;
    tx_empty        = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // One line on the chosen build. fs/fl: tx_full window by cycle after start;
  // edl: extra cycles tx_empty stays low after the last write; abort_at/restart_at: cycle or 0.
  task automatic run_line(input string nm, input bit lf, input logic [63:0] d, input int fs,
                          input int fl, input int edl, input int abort_at, input int restart_at);
    logic [7:0] q[$];
    logic [7:0] wd;
    logic       we, fl_o, bz;
    int         last = -1;
    int         n_line, dut_wr = 0, exp_wr = 0;
    bit         done = 1'b0;
    build_line(d, !lf, q);
    n_line = q.size();
    @(negedge clk);
    rdata_snd_start = 1'b1;
    rdata_snd       = d;
    tx_full         = 1'b0;
    tx_empty        = 1'b0;
    snd_abort       = 1'b0;
    for (int c = 1; c <= 150 && !done; c++) begin
      @(negedge clk);
      rdata_snd_start = (c == restart_at);
      rdata_snd       = {$urandom, $urandom};
      tx_full         = (c >= fs && c < fs + fl);
      snd_abort       = (c == abort_at);
      tx_empty        = (last >= 0 && c >= last + 1 + edl);
      #1;
      wd   = lf ? wd0 : wd1;
      we   = lf ? we0 : we1;
      fl_o = lf ? fl0 : fl1;
      bz   = lf ? bz0 : bz1;
      if (we) dut_wr++;
      if (abort_at > 0 && c > abort_at) begin
        chk({nm, " post-abort we"}, we, 0);
        chk({nm, " post-abort flush"}, fl_o, 0);
        chk({nm, " post-abort busy"}, bz, 0);
        if (c == abort_at + 3) done = 1'b1;
      end else if (q.size() > 0) begin
        chk({nm, " we"}, we, !tx_full && !snd_abort);
        chk({nm, " busy"}, bz, 1);
        chk({nm, " flush early"}, fl_o, 0);
        if (!tx_full && !snd_abort) exp_wr++;
        if (we) begin
          chk({nm, " byte"}, wd, q[0]);
          void'(q.pop_front());
          if (q.size() == 0) last = c;
        end
      end else begin
        chk({nm, " drain we"}, we, 0);
        chk({nm, " flush"}, fl_o, c == last + 2 + edl);
        chk({nm, " drain busy"}, bz, c <= last + 2 + edl);
        if (c == last + 3 + edl) done = 1'b1;
      end
      if (!we) chk({nm, " idle wdata"}, wd, 8'h00);
    end
    if (!done) chk({nm, " timeout"}, 0, 1);
    chk({nm, " byte count"}, dut_wr, (abort_at > 0) ? exp_wr : n_line);
    settle();
  endtask

  initial begin
    rst             = 1'b1;
    rdata_snd_start = 1'b0;
    rdata_snd       = 64'h0;
    snd_abort       = 1'b0;
    tx_full         = 1'b0;
    tx_empty        = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset we", {we1, we0}, 2'b00);
    chk("reset wdata", {wd1, wd0}, 16'h0);
    chk("reset flush", {fl1, fl0}, 2'b00);
    chk("reset busy", {bz1, bz0}, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    run_line("basic", 1'b0, 64'h0123456789ABCDEF, 100, 0, 0, 0, 0);
    run_line("backpressure", 1'b0, 64'h0123456789ABCDEF, 4, 2, 0, 0, 0);
    run_line("drain", 1'b0, 64'h0123456789ABCDEF, 100, 0, 10, 0, 0);
    run_line("abort", 1'b0, 64'h0123456789ABCDEF, 100, 0, 0, 6, 0);
    run_line("busy start", 1'b0, 64'h0123456789ABCDEF, 100, 0, 0, 0, 3);
    run_line("lf only", 1'b1, 64'hFFFFFFFF00000000, 100, 0, 0, 0, 0);

    // Abort together with start in IDLE drops the start.
    rdata_snd_start = 1'b1;
    snd_abort       = 1'b1;
    rdata_snd       = 64'hDEADBEEFCAFEF00D;
    @(negedge clk);
    rdata_snd_start = 1'b0;
    snd_abort       = 1'b0;
    #1;
    chk("abort+start busy", {bz1, bz0}, 2'b00);
    chk("abort+start we", {we1, we0}, 2'b00);
    settle();

    // Synchronous reset in the middle of a line.
    rdata_snd_start = 1'b1;
    rdata_snd       = 64'h0123456789ABCDEF;
    @(negedge clk);
    rdata_snd_start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre-reset we", we1, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midline reset we", {we1, we0}, 2'b00);
    chk("midline reset wdata", {wd1, wd0}, 16'h0);
    chk("midline reset flush", {fl1, fl0}, 2'b00);
    chk("midline reset busy", {bz1, bz0}, 2'b00);
    rst = 1'b0;
    settle();
    run_line("after reset", 1'b0, 64'hA5A55A5A0F0FF0F0, 100, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      run_line("random", 1'($urandom_range(0, 1)), {$urandom, $urandom},
               int'($urandom_range(1, 18)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 5)), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
